// File: rtl/bikelight_multi_pkg.sv
// rtl/bikelight_multi_pkg.sv - mode encodings and mode sequencing helper for the bike light
package bikelight_multi_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_BLINK = 3'd2,
    MODE_CHASE = 3'd3,
    MODE_DIM   = 3'd4
  } mode_e;

  // Short-press successor; unreachable codes fall back to OFF.
  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_OFF:   return MODE_ON;
      MODE_ON:    return MODE_BLINK;
      MODE_BLINK: return MODE_CHASE;
      MODE_CHASE: return MODE_DIM;
      default:    return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/bikelight_multi_if.sv
// rtl/bikelight_multi_if.sv - button in, mode and LED drive out
interface bikelight_multi_if #(
  parameter int N_LED = 4
);
  import bikelight_multi_pkg::*;

  logic              btn;
  logic [MODE_W-1:0] mode;
  logic [N_LED-1:0]  led;

  modport master (output btn, input mode, input led);
  modport slave  (input btn, output mode, output led);
endinterface

// File: rtl/bikelight_multi_btn_debounce.sv
// rtl/bikelight_multi_btn_debounce.sv - synchroniser, debouncer and hold timer producing press pulses
module bikelight_multi_btn_debounce #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_PRESS   = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic short_press,
  output logic long_press
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(LONG_PRESS + 1);
  localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS);
  localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS - 1);

  logic          sync1, sync2, deb;
  logic [DW-1:0] cnt;
  logic [HW-1:0] hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      deb         <= 1'b0;
      cnt         <= '0;
      hold        <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      sync1       <= btn;
      sync2       <= sync1;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      if (sync2 != deb) begin
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          deb <= sync2;
          // Excluding hold==LONG_PRESS-1 keeps short and long exclusive when both land on one edge.
          if (!sync2 && (hold < HOLD_PRE)) short_press <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (!deb) begin
        hold <= '0;
      end else if (hold != HOLD_MAX) begin
        hold <= hold + 1'b1;
        if (hold == HOLD_PRE) long_press <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bikelight_multi.sv
// rtl/bikelight_multi.sv - five-mode bike light: mode FSM, blink/chase tick, free-running dim PWM
module bikelight_multi
  import bikelight_multi_pkg::*;
#(
  parameter int N_LED        = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int LONG_PRESS   = 64,
  parameter int BLINK_HALF   = 8,
  parameter int PWM_BITS     = 3,
  parameter int DIM_DUTY     = 2
) (
  input logic clk,
  input logic reset,
  bikelight_multi_if.slave bus
);

  localparam int TW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(BLINK_HALF - 1);
  localparam logic [31:0]   DUTY      = 32'(DIM_DUTY);

  logic                short_press, long_press;
  mode_e               mode_q, mode_d;
  logic [TW-1:0]       tick;
  logic                phase;
  logic [N_LED-1:0]    chase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [N_LED-1:0]    led_q, led_d;
  logic                dim_on;

  bikelight_multi_btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .LONG_PRESS   (LONG_PRESS)
  ) u_btn (
    .clk         (clk),
    .reset       (reset),
    .btn         (bus.btn),
    .short_press (short_press),
    .long_press  (long_press)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode_q <= MODE_OFF;
    else       mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (mode_q > MODE_DIM)                        mode_d = MODE_OFF;
    else if (long_press && (mode_q != MODE_OFF))  mode_d = MODE_OFF;
    else if (short_press)                         mode_d = next_mode(mode_q);
  end

  // phase/chase advance together with tick so blink and chase share one step timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick    <= '0;
      phase   <= 1'b0;
      chase   <= N_LED'(1);
      pwm_cnt <= '0;
      led_q   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_q   <= led_d;
      if (mode_d != mode_q) begin
        tick  <= '0;
        phase <= 1'b0;
        chase <= N_LED'(1);
      end else if (tick == TICK_LAST) begin
        tick  <= '0;
        phase <= ~phase;
        chase <= {chase[N_LED-2:0], chase[N_LED-1]};
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  assign dim_on = ({{(32-PWM_BITS){1'b0}}, pwm_cnt} < DUTY);

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_ON:    led_d = '1;
      MODE_BLINK: led_d = phase ? '0 : '1;
      MODE_CHASE: led_d = chase;
      MODE_DIM:   led_d = {N_LED{dim_on}};
      default:    led_d = '0;
    endcase
  end

  assign bus.mode = mode_q;
  assign bus.led  = led_q;

endmodule

// File: tb/tb_bikelight_multi.sv
// tb/tb_bikelight_multi.sv - directed self-checking bench for bikelight_multi
module tb_bikelight_multi;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bikelight_multi_if #(.N_LED(4)) bus ();

  bikelight_multi dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Release edge to mode change is 2 sync + DEBOUNCE_CYC + 1 register stage = 19 cycles.
  task automatic release_check(input string tag, input int old_m, input int new_m);
    bus.btn = 1'b0;
    cycles(18);
    check_val({tag, "_before"}, 32'(bus.mode), 32'(old_m));
    cycles(1);
    check_val({tag, "_after"}, 32'(bus.mode), 32'(new_m));
  endtask

  task automatic short_press(input string tag, input int old_m, input int new_m);
    bus.btn = 1'b1;
    cycles(30);
    release_check(tag, old_m, new_m);
  endtask

  initial begin
    int lit, bad, win, bad_win;
    logic [3:0] exp_led;

    reset   = 1'b1;
    bus.btn = 1'b0;
    cycles(3);
    check_val("rst_mode", 32'(bus.mode), 0);
    check_val("rst_led", 32'(bus.led), 0);
    reset = 1'b0;
    cycles(5);

    short_press("p_on", 0, 1);
    cycles(1);
    check_val("on_led", 32'(bus.led), 32'hf);

    for (int i = 0; i < 40; i++) begin
      bus.btn = ((i / 3) % 2 == 0);
      cycles(1);
    end
    bus.btn = 1'b0;
    cycles(30);
    check_val("bounce_mode", 32'(bus.mode), 1);
    check_val("bounce_led", 32'(bus.led), 32'hf);

    short_press("p_blink", 1, 2);
    cycles(1);
    check_val("blink_first", 32'(bus.led), 32'hf);
    cycles(7);
    check_val("blink_lit_end", 32'(bus.led), 32'hf);
    cycles(1);
    check_val("blink_dark", 32'(bus.led), 0);
    cycles(7);
    check_val("blink_dark_end", 32'(bus.led), 0);
    cycles(1);
    check_val("blink_relit", 32'(bus.led), 32'hf);

    bus.btn = 1'b1;
    cycles(82);
    check_val("long_before", 32'(bus.mode), 2);
    cycles(1);
    check_val("long_off", 32'(bus.mode), 0);
    cycles(17);
    bus.btn = 1'b0;
    cycles(30);
    check_val("long_release", 32'(bus.mode), 0);
    check_val("long_led", 32'(bus.led), 0);

    bus.btn = 1'b1;
    cycles(100);
    bus.btn = 1'b0;
    cycles(30);
    check_val("hold_off", 32'(bus.mode), 0);

    short_press("s1", 0, 1);
    short_press("s2", 1, 2);
    short_press("s3", 2, 3);
    cycles(1);
    for (int k = 0; k < 5; k++) begin
      exp_led = 4'b0001 << (k % 4);
      check_val("chase_step", 32'(bus.led), 32'(exp_led));
      cycles(7);
      check_val("chase_hold", 32'(bus.led), 32'(exp_led));
      cycles(1);
    end

    short_press("s4", 3, 4);
    cycles(1);
    lit = 0; bad = 0; bad_win = 0;
    for (int w = 0; w < 8; w++) begin
      win = 0;
      for (int j = 0; j < 8; j++) begin
        if (bus.led == 4'hf) begin lit++; win++; end
        else if (bus.led != 4'h0) bad++;
        cycles(1);
      end
      if (win != 2) bad_win++;
    end
    check_val("dim_lit_total", 32'(lit), 16);
    check_val("dim_bad_pattern", 32'(bad), 0);
    check_val("dim_bad_window", 32'(bad_win), 0);

    short_press("s5", 4, 0);
    cycles(1);
    check_val("wrap_led", 32'(bus.led), 0);

    short_press("pre_rst", 0, 1);
    bus.btn = 1'b1;
    cycles(25);
    #2 reset = 1'b1;
    #1;
    check_val("arst_mode", 32'(bus.mode), 0);
    check_val("arst_led", 32'(bus.led), 0);
    cycles(2);
    reset = 1'b0;
    cycles(30);
    check_val("post_rst_hold", 32'(bus.mode), 0);
    release_check("post_rst", 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
